// File: rtl/parity_work_element.sv
// parity_work_element: CAPI AFU work element that computes a parity stripe.
// The job first fetches a 128-byte work element descriptor (WED) from host
// memory. It then reads the two source stripes one cacheline at a time and
// writes stripe1 XOR stripe2 to the parity buffer. Finally it writes the WED
// back with its done flag (byte 32) set to 0x01.
//
// Ports:
//   clock        single clock, all logic on the rising edge
//   reset        asynchronous, active-low reset
//   enable       job running; low stalls command issue (responses still absorbed)
//   job_in       job interface; .address is the WED pointer
//   command_in   PSL command credits (.room)
//   command_out  PSL command request, a one-cycle valid pulse per command
//   buffer_in    PSL buffer traffic: write_* delivers read data, read_* fetches write data
//   buffer_out   write data returned to the PSL, one cycle after read_valid
//   response     PSL command responses (code 0 = DONE)

package parity_work_element_pkg;

  localparam int LINE_BYTES = 128;

  localparam logic [12:0] CMD_READ_CL_NA = 13'h0A00;
  localparam logic [12:0] CMD_WRITE_NA   = 13'h0D00;

  typedef struct packed {
    logic [63:0] address;
  } job_interface_input_t;

  typedef struct packed {
    logic [7:0] room;
  } command_interface_input_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic        tagpar;
    logic [12:0] command;
    logic        compar;
    logic [2:0]  abt;
    logic [63:0] address;
    logic        abpar;
    logic [15:0] context_handle;
    logic [11:0] size;
  } command_interface_output_t;

  typedef struct packed {
    logic         read_valid;
    logic [7:0]   read_tag;
    logic [5:0]   read_address;
    logic         write_valid;
    logic [7:0]   write_tag;
    logic [5:0]   write_address;
    logic [511:0] write_data;
  } buffer_interface_input_t;

  typedef struct packed {
    logic [3:0]   read_latency;
    logic [511:0] read_data;
    logic [7:0]   read_parity;
  } buffer_interface_output_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [7:0] code;
  } response_interface_t;

endpackage

module parity_work_element
  import parity_work_element_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  job_interface_input_t      job_in,
  input  command_interface_input_t  command_in,
  output command_interface_output_t command_out,
  input  buffer_interface_input_t   buffer_in,
  output buffer_interface_output_t  buffer_out,
  input  response_interface_t       response
);

  typedef enum logic [3:0] {
    IDLE, WED_REQ, WED_WAIT, LINE_REQ, LINE_WAIT,
    WRITE_REQ, WRITE_WAIT, DONE_REQ, DONE_WAIT, FINISHED
  } state_t;

  state_t state, state_next;

  logic [1023:0] wed_line, stripe1_line, stripe2_line;
  logic [1023:0] wed_flagged, parity_line;
  logic [63:0]   size_q, stripe1_addr, stripe2_addr, parity_addr, offset;
  logic          line_second, line_done1, line_done2;
  logic [4:0]    retry_pending, resp_ok, resp_bad, issue_mask;
  logic          can_issue, issue;
  logic [2:0]    issue_tag;
  command_interface_output_t command_q, command_next;
  logic [511:0]  read_half, read_data_q;
  logic [7:0]    read_parity_next, read_parity_q;

  // Decode the response bus into per-tag DONE / failed strobes; tags above 4
  // match nothing and are therefore ignored.
  always_comb begin
    resp_ok  = '0;
    resp_bad = '0;
    for (int t = 0; t < 5; t++) begin
      resp_ok[t]  = response.valid && (response.tag == 8'(t)) && (response.code == 8'd0);
      resp_bad[t] = response.valid && (response.tag == 8'(t)) && (response.code != 8'd0);
    end
  end

  assign can_issue = enable && (command_in.room != 8'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and command selection. Wait states also reissue any command
  // whose response came back with a non-zero code.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_tag  = 3'd0;
    case (state)
      IDLE: if (enable) state_next = WED_REQ;
      WED_REQ: if (can_issue) begin
        issue      = 1'b1;
        issue_tag  = 3'd0;
        state_next = WED_WAIT;
      end
      WED_WAIT: begin
        if (can_issue && retry_pending[0]) begin
          issue     = 1'b1;
          issue_tag = 3'd0;
        end
        if (resp_ok[0]) state_next = (wed_line[63:0] == 64'd0) ? DONE_REQ : LINE_REQ;
      end
      LINE_REQ: if (can_issue) begin
        issue     = 1'b1;
        issue_tag = line_second ? 3'd2 : 3'd1;
        if (line_second) state_next = LINE_WAIT;
      end
      LINE_WAIT: begin
        if (can_issue && retry_pending[1]) begin
          issue     = 1'b1;
          issue_tag = 3'd1;
        end else if (can_issue && retry_pending[2]) begin
          issue     = 1'b1;
          issue_tag = 3'd2;
        end
        if ((line_done1 || resp_ok[1]) && (line_done2 || resp_ok[2])) state_next = WRITE_REQ;
      end
      WRITE_REQ: if (can_issue) begin
        issue      = 1'b1;
        issue_tag  = 3'd3;
        state_next = WRITE_WAIT;
      end
      WRITE_WAIT: begin
        if (can_issue && retry_pending[3]) begin
          issue     = 1'b1;
          issue_tag = 3'd3;
        end
        if (resp_ok[3])
          state_next = (offset + 64'(LINE_BYTES) == size_q) ? DONE_REQ : LINE_REQ;
      end
      DONE_REQ: if (can_issue) begin
        issue      = 1'b1;
        issue_tag  = 3'd4;
        state_next = DONE_WAIT;
      end
      DONE_WAIT: begin
        if (can_issue && retry_pending[4]) begin
          issue     = 1'b1;
          issue_tag = 3'd4;
        end
        if (resp_ok[4]) state_next = FINISHED;
      end
      FINISHED: state_next = FINISHED;
      default:  state_next = IDLE;
    endcase
  end

  // The tag alone determines the command and address, so a retry rebuilds
  // exactly the command that failed.
  always_comb begin
    command_next                = '0;
    command_next.valid          = issue;
    command_next.tag            = {5'd0, issue_tag};
    command_next.size           = 12'(LINE_BYTES);
    case (issue_tag)
      3'd0: begin command_next.command = CMD_READ_CL_NA; command_next.address = job_in.address; end
      3'd1: begin command_next.command = CMD_READ_CL_NA; command_next.address = stripe1_addr + offset; end
      3'd2: begin command_next.command = CMD_READ_CL_NA; command_next.address = stripe2_addr + offset; end
      3'd3: begin command_next.command = CMD_WRITE_NA;   command_next.address = parity_addr + offset; end
      default: begin command_next.command = CMD_WRITE_NA; command_next.address = job_in.address; end
    endcase
    command_next.tagpar = ~^command_next.tag;
    command_next.compar = ~^command_next.command;
    command_next.abpar  = ~^command_next.address;
  end

  assign issue_mask = issue ? (5'd1 << issue_tag) : 5'd0;

  // Command register: valid is only ever a single-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     command_q <= '0;
    else if (issue) command_q <= command_next;
    else            command_q <= '0;
  end

  assign command_out = command_q;

  // Job bookkeeping: latched WED fields, line offset, retry and line-read
  // completion flags. A failed response outranks the issue that clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      size_q        <= '0;
      stripe1_addr  <= '0;
      stripe2_addr  <= '0;
      parity_addr   <= '0;
      offset        <= '0;
      line_second   <= 1'b0;
      line_done1    <= 1'b0;
      line_done2    <= 1'b0;
      retry_pending <= '0;
    end else begin
      retry_pending <= (retry_pending & ~issue_mask) | resp_bad;
      if (state == WED_WAIT && resp_ok[0]) begin
        size_q       <= wed_line[63:0];
        stripe1_addr <= wed_line[127:64];
        stripe2_addr <= wed_line[191:128];
        parity_addr  <= wed_line[255:192];
        offset       <= '0;
      end
      if (state == WRITE_WAIT && resp_ok[3]) offset <= offset + 64'(LINE_BYTES);
      if (state == LINE_REQ && issue) line_second <= ~line_second;
      if (state_next == LINE_REQ && state != LINE_REQ) begin
        line_done1 <= 1'b0;
        line_done2 <= 1'b0;
      end else begin
        line_done1 <= line_done1 | resp_ok[1];
        line_done2 <= line_done2 | resp_ok[2];
      end
    end
  end

  // Incoming read data lands in the line buffer chosen by write_tag;
  // write_address[0] picks the upper or lower 64 bytes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wed_line     <= '0;
      stripe1_line <= '0;
      stripe2_line <= '0;
    end else if (buffer_in.write_valid) begin
      case (buffer_in.write_tag)
        8'd0: if (buffer_in.write_address[0]) wed_line[1023:512] <= buffer_in.write_data;
              else                            wed_line[511:0]    <= buffer_in.write_data;
        8'd1: if (buffer_in.write_address[0]) stripe1_line[1023:512] <= buffer_in.write_data;
              else                            stripe1_line[511:0]    <= buffer_in.write_data;
        8'd2: if (buffer_in.write_address[0]) stripe2_line[1023:512] <= buffer_in.write_data;
              else                            stripe2_line[511:0]    <= buffer_in.write_data;
        default: ;
      endcase
    end
  end

  // Outgoing write data is derived from the line buffers rather than stored,
  // and the per-64-bit odd parity is computed alongside it.
  always_comb begin
    wed_flagged          = wed_line;
    wed_flagged[263:256] = 8'h01;
    parity_line          = stripe1_line ^ stripe2_line;
    read_half            = '0;
    case (buffer_in.read_tag)
      8'd3: read_half = buffer_in.read_address[0] ? parity_line[1023:512] : parity_line[511:0];
      8'd4: read_half = buffer_in.read_address[0] ? wed_flagged[1023:512] : wed_flagged[511:0];
      default: read_half = '0;
    endcase
    read_parity_next = '0;
    for (int k = 0; k < 8; k++) read_parity_next[k] = ~^read_half[64*k +: 64];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data_q   <= '0;
      read_parity_q <= '0;
    end else if (buffer_in.read_valid) begin
      read_data_q   <= read_half;
      read_parity_q <= read_parity_next;
    end
  end

  assign buffer_out.read_latency = 4'd1;
  assign buffer_out.read_data    = read_data_q;
  assign buffer_out.read_parity  = read_parity_q;

endmodule

// File: tb/tb_parity_work_element.sv
// tb_parity_work_element: self-checking bench for parity_work_element.
// Emulates the PSL and host memory (associative array of cachelines) and
// compares issued commands and written memory against a reference model.

module tb_parity_work_element;
  import parity_work_element_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  job_interface_input_t      job_in;
  command_interface_input_t  command_in;
  command_interface_output_t command_out;
  buffer_interface_input_t   buffer_in;
  buffer_interface_output_t  buffer_out;
  response_interface_t       response;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  tag;
    logic [12:0] command;
    logic [63:0] address;
  } exp_cmd_t;

  command_interface_output_t cmd_q[$];
  command_interface_output_t log_q[$];
  exp_cmd_t                  exp_q[$];
  logic [1023:0]             mem [bit [63:0]];

  logic [63:0]  job_addr, s1_addr, s2_addr, par_addr;
  logic [1023:0] wed_orig;
  logic [7:0]   last_t3_p0, last_t3_p1;

  always #5 clock = ~clock;

  parity_work_element dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .job_in     (job_in),
    .command_in (command_in),
    .command_out(command_out),
    .buffer_in  (buffer_in),
    .buffer_out (buffer_out),
    .response   (response)
  );

  // Command monitor: every valid pulse is queued for the PSL emulation.
  always @(negedge clock) begin
    if (command_out.valid === 1'b1) cmd_q.push_back(command_out);
  end

  task automatic check_output(input string name, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [1023:0] rand_line();
    logic [1023:0] l;
    for (int i = 0; i < 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [63:0] rand_base(input int id);
    logic [63:0] a;
    a = {4'(id), 28'($urandom), 32'($urandom)};
    a[11:0] = 12'h000;
    return a;
  endfunction

  function automatic logic [1023:0] xor_lines(input logic [1023:0] a, input logic [1023:0] b);
    logic [1023:0] r;
    for (int i = 0; i < 128; i++) r[8*i +: 8] = a[8*i +: 8] ^ b[8*i +: 8];
    return r;
  endfunction

  function automatic logic [7:0] odd_parity(input logic [511:0] d);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) p[k] = ~^d[64*k +: 64];
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    buffer_in = '0;
    response = '0;
    command_in.room = 8'd16;
    tick(3);
    reset = 1'b1;
    tick(1);
    cmd_q.delete();
    log_q.delete();
  endtask

  task automatic serve_read(input logic [7:0] tag, input logic [1023:0] line);
    buffer_in.write_valid = 1'b1;
    buffer_in.write_tag = tag;
    buffer_in.write_address = 6'd0;
    buffer_in.write_data = line[511:0];
    tick(1);
    buffer_in.write_address = 6'd1;
    buffer_in.write_data = line[1023:512];
    tick(1);
    buffer_in.write_valid = 1'b0;
  endtask

  task automatic serve_write(input logic [7:0] tag, output logic [1023:0] line, output logic [7:0] p0, output logic [7:0] p1);
    buffer_in.read_valid = 1'b1;
    buffer_in.read_tag = tag;
    buffer_in.read_address = 6'd0;
    tick(1);
    line[511:0] = buffer_out.read_data;
    p0 = buffer_out.read_parity;
    buffer_in.read_address = 6'd1;
    tick(1);
    line[1023:512] = buffer_out.read_data;
    p1 = buffer_out.read_parity;
    buffer_in.read_valid = 1'b0;
  endtask

  task automatic respond(input logic [7:0] tag, input logic [7:0] code);
    response.valid = 1'b1;
    response.tag = tag;
    response.code = code;
    tick(1);
    response = '0;
  endtask

  task automatic check_cmd_format(input command_interface_output_t c);
    check_output("cmd_fixed_fields", {c.abt, c.context_handle, c.size}, {3'd0, 16'd0, 12'd128});
    check_output("cmd_parity_bits", {c.tagpar, c.compar, c.abpar}, {~^c.tag, ~^c.command, ~^c.address});
  endtask

  // PSL emulation: serve queued commands from/into host memory until the
  // done write completes or the idle budget runs out.
  task automatic apply_stimulus(input int budget, input bit fail_t3_once);
    command_interface_output_t c;
    logic [1023:0] line;
    logic [7:0] p0, p1;
    int idle = 0;
    bit injected = 1'b0;
    bit finished = 1'b0;
    while (!finished && idle < budget) begin
      if (cmd_q.size() == 0) begin
        tick(1);
        idle++;
      end else begin
        c = cmd_q.pop_front();
        log_q.push_back(c);
        check_cmd_format(c);
        if (c.command == CMD_READ_CL_NA) begin
          line = mem.exists(c.address) ? mem[c.address] : '0;
          serve_read(c.tag, line);
          respond(c.tag, 8'd0);
        end else begin
          serve_write(c.tag, line, p0, p1);
          check_output("read_parity_lo", p0, odd_parity(line[511:0]));
          check_output("read_parity_hi", p1, odd_parity(line[1023:512]));
          if (c.tag == 8'd3) begin
            last_t3_p0 = p0;
            last_t3_p1 = p1;
          end
          if (fail_t3_once && c.tag == 8'd3 && !injected) begin
            injected = 1'b1;
            respond(8'd3, 8'h01);
          end else begin
            mem[c.address] = line;
            respond(c.tag, 8'd0);
            if (c.tag == 8'd4) finished = 1'b1;
          end
        end
      end
    end
    check_output("job_finished", 512'(finished), 512'd1);
  endtask

  // Reference command sequence straight from the job description.
  task automatic build_expected(input logic [63:0] size, input bit retry_t3);
    exp_q.delete();
    exp_q.push_back({8'd0, CMD_READ_CL_NA, job_addr});
    for (logic [63:0] o = 0; o < size; o += 128) begin
      exp_q.push_back({8'd1, CMD_READ_CL_NA, s1_addr + o});
      exp_q.push_back({8'd2, CMD_READ_CL_NA, s2_addr + o});
      exp_q.push_back({8'd3, CMD_WRITE_NA, par_addr + o});
      if (retry_t3 && o == 0) exp_q.push_back({8'd3, CMD_WRITE_NA, par_addr + o});
    end
    exp_q.push_back({8'd4, CMD_WRITE_NA, job_addr});
  endtask

  task automatic check_output_job(input logic [63:0] size);
    logic [1023:0] got, exp;
    check_output("cmd_count", 512'(log_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check_output($sformatf("cmd_seq[%0d]", i), {log_q[i].tag, log_q[i].command, log_q[i].address}, exp_q[i]);
    for (logic [63:0] o = 0; o < size; o += 128) begin
      got = mem.exists(par_addr + o) ? mem[par_addr + o] : '0;
      exp = xor_lines(mem[s1_addr + o], mem[s2_addr + o]);
      check_output("parity_line_lo", got[511:0], exp[511:0]);
      check_output("parity_line_hi", got[1023:512], exp[1023:512]);
    end
    exp = wed_orig;
    exp[8*32 +: 8] = 8'h01;
    got = mem[job_addr];
    check_output("wed_done_lo", got[511:0], exp[511:0]);
    check_output("wed_done_hi", got[1023:512], exp[1023:512]);
  endtask

  task automatic setup_job(input logic [63:0] size, input bit pattern);
    mem.delete();
    job_addr = rand_base(1);
    s1_addr = rand_base(2);
    s2_addr = rand_base(3);
    par_addr = rand_base(4);
    wed_orig = rand_line();
    wed_orig[63:0] = size;
    wed_orig[127:64] = s1_addr;
    wed_orig[191:128] = s2_addr;
    wed_orig[255:192] = par_addr;
    wed_orig[263:256] = 8'h00;
    mem[job_addr] = wed_orig;
    job_in.address = job_addr;
    for (logic [63:0] o = 0; o < size; o += 128) begin
      mem[s1_addr + o] = pattern ? {128{8'hAA}} : rand_line();
      mem[s2_addr + o] = pattern ? {128{8'h0F}} : rand_line();
    end
  endtask

  task automatic run_job(input logic [63:0] size, input bit pattern, input bit fail_t3);
    do_reset();
    setup_job(size, pattern);
    build_expected(size, fail_t3);
    enable = 1'b1;
    apply_stimulus(300, fail_t3);
    check_output_job(size);
  endtask

  task automatic wait_queue(input int n, input int budget, output bit ok);
    int k = 0;
    while (cmd_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = (cmd_q.size() >= n);
  endtask

  initial begin
    command_interface_output_t c;
    logic [1023:0] wline;
    bit ok;
    job_in = '0;
    buffer_in = '0;
    response = '0;
    command_in.room = 8'd16;

    // Reset state
    tick(2);
    check_output("reset_command_out", command_out, '0);
    check_output("reset_read_data", buffer_out.read_data, '0);
    check_output("reset_read_parity", buffer_out.read_parity, '0);
    check_output("reset_read_latency", buffer_out.read_latency, 4'd1);

    // Empty job: WED read then done write only
    run_job(64'd0, 1'b0, 1'b0);

    // One line of 0xAA ^ 0x0F
    run_job(64'd128, 1'b1, 1'b0);
    wline = mem[par_addr];
    check_output("a5_line_lo", wline[511:0], {64{8'hA5}});
    check_output("a5_line_hi", wline[1023:512], {64{8'hA5}});
    check_output("a5_parity", {last_t3_p1, last_t3_p0}, 16'hFFFF);

    // Three random lines
    run_job(64'd384, 1'b0, 1'b0);

    // Tag-3 failure once, then retry
    run_job(64'd256, 1'b0, 1'b1);

    // No credits for the first cycles of the job
    do_reset();
    setup_job(64'd0, 1'b0);
    command_in.room = 8'd0;
    enable = 1'b1;
    tick(6);
    check_output("no_cmd_without_room", 512'(cmd_q.size()), 512'd0);
    command_in.room = 8'd1;
    wait_queue(1, 20, ok);
    check_output("cmd_after_room", 512'(ok), 512'd1);
    tick(3);
    check_output("single_pulse", 512'(cmd_q.size()), 512'd1);
    c = (cmd_q.size() > 0) ? cmd_q[0] : '0;
    check_output("room_cmd", {c.tag, c.command, c.address}, {8'd0, CMD_READ_CL_NA, job_addr});

    // Reset in the middle of LINE_WAIT
    do_reset();
    setup_job(64'd128, 1'b0);
    enable = 1'b1;
    wait_queue(1, 20, ok);
    check_output("midjob_wed_cmd", 512'(ok), 512'd1);
    c = (cmd_q.size() > 0) ? cmd_q.pop_front() : '0;
    serve_read(8'd0, mem[job_addr]);
    respond(8'd0, 8'd0);
    wait_queue(2, 20, ok);
    check_output("midjob_line_cmds", 512'(ok), 512'd1);
    reset = 1'b0;
    tick(1);
    check_output("midjob_reset_valid", command_out.valid, 1'b0);
    check_output("midjob_reset_latency", buffer_out.read_latency, 4'd1);
    enable = 1'b0;
    reset = 1'b1;
    cmd_q.delete();
    tick(10);
    check_output("idle_after_reset", 512'(cmd_q.size()), 512'd0);
    enable = 1'b1;
    wait_queue(1, 20, ok);
    c = (cmd_q.size() > 0) ? cmd_q[0] : '0;
    check_output("restart_from_idle", {c.valid, c.tag, c.command, c.address}, {1'b1, 8'd0, CMD_READ_CL_NA, job_addr});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
